uart_tx_arbiter: RTL

Packet-level round-robin arbiter that shares the debug unit's single UART transmitter among `NUM_REQ` byte-stream requesters, such as the register dump, memory dump and status reporters. It sits between the requesters and the UART TX datapath, which is paced by the baud-rate tick generator. It grants the transmitter to one requester for a whole packet, terminated by `req_last`, and issues one `tx_start` pulse per byte. It waits for `tx_done` before the next byte, and releases a stalled grant after a timeout.

---
 rtl/debug_uart_pkg.sv | 13 +
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/debug_uart_pkg.sv
// Types and defaults shared by the debug unit's UART transmit path.
package debug_uart_pkg;

  localparam int DEFAULT_DATA_W  = 8;
  localparam int DEFAULT_NUM_REQ = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BUSY
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of req after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  // Search ptr+1, ptr+2, ... so the last served index gets lowest priority.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter among several
// byte-stream requesters, with a stall timeout that revokes an idle grant.
module uart_tx_arbiter
  import debug_uart_pkg::*;
#(
  parameter int NUM_REQ       = DEFAULT_NUM_REQ,
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int STALL_TIMEOUT = 1023
) (
  input  logic                        CLK_100MHZ,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_done,
  output logic                        grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        abort
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(STALL_TIMEOUT);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_next;
  logic             last_q;
  logic             handshake;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign handshake  = (state == LOAD) && req_valid[grant_id];
  assign stall_next = stall_cnt + CNT_W'(1);

  // Ready depends only on state and grant so a requester never sees a loop through valid.
  always_comb begin
    req_ready = '0;
    if (state == LOAD) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge CLK_100MHZ) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
      grant_valid <= 1'b0;
      grant_id    <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      abort       <= 1'b0;
      stall_cnt   <= '0;
      last_q      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      abort    <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            stall_cnt   <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (handshake) begin
            tx_data   <= req_data[grant_id*DATA_W +: DATA_W];
            last_q    <= req_last[grant_id];
            tx_start  <= 1'b1;
            stall_cnt <= '0;
            state     <= BUSY;
          end else if (stall_next == STALL_LIMIT) begin
            // Revoked requester drops to lowest priority, same as a completed packet.
            abort       <= 1'b1;
            rr_ptr      <= grant_id;
            grant_valid <= 1'b0;
            stall_cnt   <= '0;
            state       <= IDLE;
          end else begin
            stall_cnt <= stall_next;
          end
        end
        BUSY: begin
          if (tx_done) begin
            if (last_q) begin
              rr_ptr      <= grant_id;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end else begin
              stall_cnt <= '0;
              state     <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
